pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV32I pipeline. It drives the load enables and bubble-insert (flush) strobes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Inputs are the hazard-relevant fields those registers present, plus the instruction- and data-memory response handshakes. It also keeps stall/flush performance counters and a memory-wait timeout flag.

---
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Produces pipeline-register load enables and bubble strobes, keeps
// saturating stall/flush counters and a sticky memory-wait timeout flag.
module pipeline_hazard_ctrl #(
    parameter int CNT_WIDTH    = 16,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_is_load,
    input  logic                 ex_regwrite,
    input  logic                 redirect,
    input  logic                 imem_resp,
    input  logic                 dmem_access,
    input  logic                 dmem_resp,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic                 timeout_err
);

    localparam int WAIT_W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              active;
    logic              mem_busy;
    logic              load_use;
    logic              stall;
    logic              flush_accept;

    // Hazard detection and priority-ordered pipeline control.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // block leaves a signal unassigned, which would infer a latch.
        pc_load      = 1'b0;
        if_id_load   = 1'b0;
        id_ex_load   = 1'b0;
        ex_mem_load  = 1'b0;
        mem_wb_load  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;

        active   = (state == RUN) || (state == MEMWAIT);
        mem_busy = !imem_resp || (dmem_access && !dmem_resp);
        load_use = ex_is_load && ex_regwrite && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));

        stall        = active && (mem_busy || (load_use && !redirect));
        flush_accept = active && !mem_busy && redirect;

        if (active && !mem_busy) begin
            // Every non-frozen case advances the back end of the pipe.
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if (redirect) begin
                // Redirect squashes the wrong-path work, which also removes
                // any load-use dependency in the same cycle.
                pc_load      = 1'b1;
                if_id_load   = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, insert a bubble into ID/EX.
                flush_id_ex = 1'b1;
            end else begin
                pc_load    = 1'b1;
                if_id_load = 1'b1;
            end
        end
    end

    // State sequencing, saturating counters and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                BOOT:         state <= RUN;
                RUN, MEMWAIT: state <= mem_busy ? MEMWAIT : RUN;
                default:      state <= BOOT;
            endcase

            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);

            if (flush_accept && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);

            if (active && mem_busy) begin
                if (int'(wait_cnt) < WAIT_TIMEOUT)
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                // Flag rises on the edge where the count reaches the limit.
                if (int'(wait_cnt) + 1 >= WAIT_TIMEOUT)
                    timeout_err <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table of directed vectors
// in RUN state plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

    localparam int CW      = 4;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_regwrite;
    logic          redirect, imem_resp, dmem_access, dmem_resp;
    logic          pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic          flush_if_id, flush_id_ex, flush_ex_mem;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       rw;
        logic       redir;
        logic       iresp;
        logic       dacc;
        logic       dresp;
        logic [4:0] loads;    // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [2:0] flushes;  // {if_id, id_ex, ex_mem}
        logic       st;       // cycle counts as a stall
        logic       fl;       // cycle accepts a redirect
    } vec_t;

    vec_t tbl [13];
    vec_t v_idle, v_ibusy, v_dwait_redir, v_dresp_redir;

    pipeline_hazard_ctrl #(.CNT_WIDTH(CW), .WAIT_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite),
        .redirect(redirect), .imem_resp(imem_resp),
        .dmem_access(dmem_access), .dmem_resp(dmem_resp),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int val);
        return (val < CMAX) ? val + 1 : val;
    endfunction

    function automatic logic [4:0] loads_now();
        return {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load};
    endfunction

    function automatic logic [2:0] flushes_now();
        return {flush_if_id, flush_id_ex, flush_ex_mem};
    endfunction

    task automatic drive(input vec_t v);
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_uses_rs1 = v.u1;
        id_uses_rs2 = v.u2;
        ex_rd       = v.rd;
        ex_is_load  = v.ld;
        ex_regwrite = v.rw;
        redirect    = v.redir;
        imem_resp   = v.iresp;
        dmem_access = v.dacc;
        dmem_resp   = v.dresp;
    endtask

    // Drive one vector for one cycle (entered just after a rising edge):
    // compare controls mid-cycle, counters just after the next edge.
    task automatic apply_vec(input vec_t v, input string tag);
        drive(v);
        @(negedge clk);
        check({tag, " loads"}, 32'(loads_now()), 32'(v.loads));
        check({tag, " flushes"}, 32'(flushes_now()), 32'(v.flushes));
        @(posedge clk);
        #1;
        if (v.st) exp_stall = sat_inc(exp_stall);
        if (v.fl) exp_flush = sat_inc(exp_flush);
        check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, " flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    // Release reset just after an edge and verify the single BOOT cycle.
    task automatic release_and_boot(input string tag);
        drive(v_idle);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, " boot loads"}, 32'(loads_now()), 32'd0);
        check({tag, " boot flushes"}, 32'(flushes_now()), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " boot stall_cnt"}, 32'(stall_cnt), 32'd0);
        apply_vec(v_idle, {tag, " first run"});
    endtask

    initial begin
        v_idle        = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                          1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0, 1'b0};
        v_ibusy       = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0};
        v_dwait_redir = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
                          1'b1, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0};
        v_dresp_redir = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
                          1'b1, 1'b1, 1'b1, 5'b11111, 3'b111, 1'b0, 1'b1};

        tbl[0]  = v_idle;
        // load-use via rs2
        tbl[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b1, 1'b0};
        // same pattern with rd = x0: no stall
        tbl[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0, 1'b0};
        // load-use via rs1
        tbl[3]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b1, 1'b0};
        // indices match but neither source is read
        tbl[4]  = '{5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0, 1'b0};
        // load without regwrite
        tbl[5]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0, 1'b0};
        // ALU producer, not a load
        tbl[6]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0, 1'b0};
        // load-use plus redirect: redirect wins
        tbl[7]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b0, 1'b0, 5'b11111, 3'b111, 1'b0, 1'b1};
        // plain redirect
        tbl[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b0, 5'b11111, 3'b111, 1'b0, 1'b1};
        // fetch wait with redirect: freeze, redirect not accepted
        tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0};
        // data wait with load-use: freeze, one stall only
        tbl[10] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0};
        // data access completes
        tbl[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b1, 5'b11111, 3'b000, 1'b0, 1'b0};
        // rs1 differs from rd
        tbl[12] = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        drive(v_idle);
        #12;
        check("reset loads", 32'(loads_now()), 32'd0);
        check("reset flushes", 32'(flushes_now()), 32'd0);
        check("reset stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset flush_cnt", 32'(flush_cnt), 32'd0);
        check("reset timeout_err", 32'(timeout_err), 32'd0);
        release_and_boot("rel1");

        // Directed vector table
        for (int i = 0; i < 13; i++)
            apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Data wait of three cycles with a pending redirect
        for (int i = 0; i < 3; i++)
            apply_vec(v_dwait_redir, $sformatf("dwait%0d", i));
        apply_vec(v_dresp_redir, "dwait release");
        check("dwait timeout_err", 32'(timeout_err), 32'd0);

        // Fetch wait reaching the timeout limit
        for (int i = 1; i <= TIMEOUT; i++) begin
            apply_vec(v_ibusy, $sformatf("iwait%0d", i));
            check($sformatf("iwait%0d timeout_err", i), 32'(timeout_err),
                  32'(i >= TIMEOUT));
        end
        apply_vec(v_idle, "iwait release");
        check("timeout sticky", 32'(timeout_err), 32'd1);

        // Counter saturation
        for (int i = 0; i < 20; i++)
            apply_vec(v_ibusy, $sformatf("sat stall%0d", i));
        check("stall_cnt saturated", 32'(stall_cnt), 32'(CMAX));
        for (int i = 0; i < 20; i++)
            apply_vec(tbl[8], $sformatf("sat flush%0d", i));
        check("flush_cnt saturated", 32'(flush_cnt), 32'(CMAX));

        // Asynchronous reset in the middle of a freeze
        apply_vec(v_ibusy, "pre-reset wait0");
        apply_vec(v_ibusy, "pre-reset wait1");
        drive(v_ibusy);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset loads", 32'(loads_now()), 32'd0);
        check("async reset flushes", 32'(flushes_now()), 32'd0);
        check("async reset stall_cnt", 32'(stall_cnt), 32'd0);
        check("async reset flush_cnt", 32'(flush_cnt), 32'd0);
        check("async reset timeout_err", 32'(timeout_err), 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        release_and_boot("rel2");
        apply_vec(tbl[1], "post-reset load-use");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
